// File: rtl/alu_sequencer.sv
// Single-cycle AND/OR/ADD/SUB unit with a multi-cycle shift-add multiplier.
// MUL holds the pipeline through stall_o for WIDTH iterations; flush_i aborts it.
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    logic             w_accept;
    logic             w_accept_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_alu_result;

    assign w_accept     = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_accept_mul = w_accept && (ALUCtrl_i == OP_MUL);
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_step_acc   = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Reset gates the combinational term so stall_o is 0 during reset even with start_i high.
    assign stall_o  = rst_i && (w_accept_mul || (r_state == S_MUL));
    assign result_o = r_result;
    assign valid_o  = r_valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_alu_result = '0;
        case (ALUCtrl_i)
            OP_AND:  w_alu_result = data1_i & data2_i;
            OP_OR:   w_alu_result = data1_i | data2_i;
            OP_ADD:  w_alu_result = data1_i + data2_i;
            OP_SUB:  w_alu_result = data1_i - data2_i;
            default: w_alu_result = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept_mul) w_next_state = S_MUL;
            S_MUL:  if (flush_i || w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept_mul) begin
                        r_mcand  <= data1_i;
                        r_mplier <= data2_i;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else if (w_accept) begin
                        r_result <= w_alu_result;
                        r_valid  <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (!flush_i) begin
                        r_acc    <= w_step_acc;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        // The final step's sum goes straight to result_o at the last edge.
                        if (w_last) begin
                            r_result <= w_step_acc;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width and multiply iteration count.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start_i  input  1  operation request, qualified by ALUCtrl_i.
REQ-005 SHALL have port flush_i  input  1  synchronous abort of any in-flight operation.
REQ-006 SHALL have port ALUCtrl_i  input  3  op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL.
REQ-007 SHALL have port data1_i  input  WIDTH  operand 1 (multiplicand for MUL).
REQ-008 SHALL have port data2_i  input  WIDTH  operand 2 (multiplier for MUL).
REQ-009 SHALL have port stall_o  output  1  pipeline hold request.
REQ-010 SHALL have port result_o  output  WIDTH  registered result.
REQ-011 SHALL have port valid_o  output  1  one-cycle pulse marking a new result_o.

Function
REQ-012 SHALL implement states IDLE and MUL; MUL entered only from IDLE.
REQ-013 In IDLE, start_i=1 and flush_i=0 SHALL accept the request at that rising edge; start_i in MUL SHALL be ignored.
REQ-014 Accepted non-MUL op SHALL load result_o at the accept edge and pulse valid_o in the following cycle (latency 1); state stays IDLE.
REQ-015 AND/OR bitwise; ADD/SUB modulo 2^WIDTH, carry/borrow discarded; undefined op codes SHALL yield result_o=0 with valid_o pulse.
REQ-016 Accepted MUL SHALL capture data1_i, data2_i, clear accumulator and iteration counter, enter MUL.
REQ-017 Each MUL-state cycle SHALL perform one shift-add step: if multiplier LSB=1 add multiplicand to accumulator; shift multiplicand left 1, multiplier right 1; counter+1.
REQ-018 After exactly WIDTH iterations (no early termination), SHALL load result_o with accumulator low WIDTH bits, pulse valid_o next cycle, return to IDLE.
REQ-019 MUL latency: accept in cycle 0, iterations cycles 1..WIDTH, valid_o high in cycle WIDTH+1.
REQ-020 stall_o SHALL be combinational: 1 when (IDLE and start_i and ALUCtrl_i=011 and not flush_i) or state=MUL; else 0.
REQ-021 stall_o SHALL be 0 in the cycle valid_o pulses; back-to-back start_i SHALL be accepted in that cycle.
REQ-022 Iteration counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap before terminal count.
REQ-023 flush_i=1 in MUL SHALL return to IDLE at that edge with no valid_o and result_o unchanged; flush_i with start_i in IDLE SHALL win (no accept).
REQ-024 result_o SHALL hold its last value until the next completion.
REQ-025 valid_o SHALL never be high two consecutive cycles except for back-to-back single-cycle ops.

Reset
REQ-026 rst_i=0 SHALL immediately force state IDLE, result_o=0, valid_o=0, accumulator and counter 0, and stall_o=0 regardless of start_i.
REQ-027 Reset during MUL SHALL abandon the operation; no valid_o after release.
REQ-028 First request SHALL be accepted on the first rising edge after rst_i deasserts.

Verification
REQ-029 ADD 5+7 -> valid_o cycle 1, result_o=12, stall_o never 1.
REQ-030 SUB 3-5 -> result_o=0xFFFFFFFE; undefined op 111 -> result_o=0, valid_o pulses.
REQ-031 MUL 0x00001234*0x10 -> stall_o high cycles 0..32, valid_o cycle 33, result_o=0x00012340.
REQ-032 MUL 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001; then ADD in cycle 33 -> accepted, valid_o cycle 34.
REQ-033 MUL with start_i/ADD held during MUL, flush_i at cycle 10 -> IDLE, no valid_o, stall_o 0 cycle 11, result_o unchanged.
REQ-034 rst_i low at cycle 20 of MUL -> all outputs 0 immediately; after release ADD 1+1 -> result_o=2 at latency 1.
